// File: rtl/whirlpool_pkg.sv
// rtl/whirlpool_pkg.sv - shared constants, tables and GF(2^8) helper for the Whirlpool row datapath
package whirlpool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] GF_POLY = 8'h1D;

  // Mini-box tables shared by the forward and inverse S-box
  localparam logic [3:0] E_TAB [0:15] = '{
    4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
    4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0
  };
  localparam logic [3:0] EI_TAB [0:15] = '{
    4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
    4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6
  };
  localparam logic [3:0] R_TAB [0:15] = '{
    4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
    4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0
  };

  localparam logic [7:0] FWD_THETA_COEF [0:7] = '{
    8'h01, 8'h09, 8'h02, 8'h05, 8'h08, 8'h01, 8'h04, 8'h01
  };
  // First row of the inverse circulant; its bytes XOR to 3^-1 = F4
  localparam logic [7:0] INV_THETA_COEF [0:7] = '{
    8'h04, 8'h3E, 8'hCB, 8'hC2, 8'hC2, 8'hA4, 8'h0E, 8'hAF
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] shifted;
    prod    = '0;
    shifted = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ shifted;
      shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? GF_POLY : 8'h00);
    end
    return prod;
  endfunction

endpackage

// File: rtl/sbox_inv.sv
// rtl/sbox_inv.sv - combinational inverse Whirlpool S-box built from the E/EI/R mini-boxes
module sbox_inv
  import whirlpool_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [3:0] l_nib;
  logic [3:0] r_nib;
  logic [3:0] t_nib;

  // Forward structure with E and EI swapped
  always_comb begin
    l_nib  = EI_TAB[value[7:4]];
    r_nib  = E_TAB[value[3:0]];
    t_nib  = R_TAB[l_nib ^ r_nib];
    result = {EI_TAB[l_nib ^ t_nib], E_TAB[r_nib ^ t_nib]};
  end

endmodule

// File: rtl/process_row_inv.sv
// rtl/process_row_inv.sv - inverse Whirlpool row transform (theta^-1 then gamma^-1); PROCESS_ROW_INV_UNROLL_EN selects the 1-cycle parallel datapath
module process_row_inv
  import whirlpool_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_row,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_row,
  output logic        busy
);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] t_reg;
  logic [63:0] out_reg;
  logic        calc_last;

  // Output byte k mixes byte (m+k) mod 8 of the input row with coefficient d[m]
  function automatic logic [7:0] theta_inv_byte(input logic [63:0] t, input logic [2:0] k);
    logic [2:0] j;
    logic [7:0] acc;
    acc = '0;
    for (int m = 0; m < 8; m++) begin
      j   = 3'(m) + k;
      acc = acc ^ gf_mul(t[8*(7-j) +: 8], INV_THETA_COEF[m]);
    end
    return acc;
  endfunction

`ifdef PROCESS_ROW_INV_UNROLL_EN
  logic [63:0] calc_row;

  for (genvar g = 0; g < 8; g++) begin : g_byte
    logic [7:0] mixed;
    assign mixed = theta_inv_byte(t_reg, 3'(g));
    sbox_inv u_sbox_inv (
      .value  (mixed),
      .result (calc_row[8*(7-g) +: 8])
    );
  end

  assign calc_last = 1'b1;
`else
  logic [2:0] cnt;
  logic [7:0] mixed;
  logic [7:0] calc_byte;

  assign mixed = theta_inv_byte(t_reg, cnt);

  sbox_inv u_sbox_inv (
    .value  (mixed),
    .result (calc_byte)
  );

  assign calc_last = (cnt == 3'd7);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (calc_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset mid-row discards the partially assembled result
  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg   <= '0;
      out_reg <= '0;
`ifndef PROCESS_ROW_INV_UNROLL_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t_reg <= in_row;
`ifndef PROCESS_ROW_INV_UNROLL_EN
            cnt   <= '0;
`endif
          end
        end
        CALC: begin
`ifdef PROCESS_ROW_INV_UNROLL_EN
          out_reg <= calc_row;
`else
          out_reg[8*(7-cnt) +: 8] <= calc_byte;
          cnt                     <= cnt + 3'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_row = out_reg;

endmodule
